// File: rtl/wb_burst_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// A grant is held for the whole bus cycle, bursts included. An access the
// slave does not answer within TIMEOUT cycles is terminated with an error.
module wb_burst_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS*aw-1:0] m_adr_i,
  input  logic [NUM_MASTERS*dw-1:0] m_dat_i,
  input  logic [NUM_MASTERS*dw/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  output logic [dw-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [aw-1:0]             s_adr_o,
  output logic [dw-1:0]             s_dat_o,
  output logic [dw/8-1:0]           s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [dw-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int SW = dw / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]          r_last, w_last_nxt;
  logic [IW-1:0]          r_idx, w_idx_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   r_err, w_err_nxt;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic [IW-1:0] w_cand;
  logic          w_busy;
  logic          w_cyc_g;
  logic          w_stb_g;
  logic          w_resp;
  logic          w_stb_out;
  logic          w_to;

  assign w_busy    = (r_state == BUSY);
  assign w_cyc_g   = m_cyc_i[r_idx];
  assign w_stb_g   = m_stb_i[r_idx];
  assign w_resp    = s_ack_i | s_err_i | s_rty_i;
  // The cycle carrying the timeout error withdraws the strobe from the slave.
  assign w_stb_out = w_busy & w_stb_g & ~r_err;
  assign w_to      = w_stb_out & ~w_resp & (r_cnt == CW'(TIMEOUT - 1));
  assign m_dat_o   = s_dat_i;
  assign grant_o   = r_grant;

  // Round-robin search starting just after the last granted master.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_cand = IW'((32'(r_last) + 32'd1 + i) % 32'(NUM_MASTERS));
      if (!w_found && m_cyc_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Next-state, grant, pointer and timeout counter.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = '0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt         = BUSY;
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_last_nxt          = w_pick;
          w_idx_nxt           = w_pick;
        end
      end
      BUSY: begin
        if (!w_cyc_g) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end else begin
          w_err_nxt = w_to;
          if (w_stb_out && !w_resp && !w_to)
            w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_idx   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Slave port mux and per-master terminations for the granted master.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (w_busy) begin
      s_adr_o        = m_adr_i[r_idx*aw +: aw];
      s_dat_o        = m_dat_i[r_idx*dw +: dw];
      s_sel_o        = m_sel_i[r_idx*SW +: SW];
      s_we_o         = m_we_i[r_idx];
      s_cyc_o        = w_cyc_g;
      s_stb_o        = w_stb_out;
      s_cti_o        = m_cti_i[r_idx*3 +: 3];
      s_bte_o        = m_bte_i[r_idx*2 +: 2];
      m_ack_o[r_idx] = s_ack_i & w_stb_g;
      m_err_o[r_idx] = (s_err_i & w_stb_g) | (r_err & ~s_ack_i);
      m_rty_o[r_idx] = s_rty_i & w_stb_g;
    end
  end

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// Bench for wb_burst_arbiter: bus-functional masters and slave, plus a
// transaction-level model of ownership, round-robin order and timeout.
module tb_wb_burst_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_we, m_cyc, m_stb;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack, m_err, m_rty;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic [SW-1:0]   s_sel;
  logic            s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic [N-1:0]    grant;

  wb_burst_arbiter #(.NUM_MASTERS(N), .aw(AW), .dw(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant)
  );

  // master state
  bit          act[N];
  int          beats[N];
  logic [31:0] adr[N], dat[N];
  logic [3:0]  sel[N];
  logic [1:0]  bte[N];
  bit          we[N], bst[N];
  bit          pv[N], p_we[N], p_bst[N];
  int          p_beats[N];
  logic [31:0] p_adr[N];
  bit          rand_mode;

  // slave state
  int sl_cnt, sl_D, sl_kind, dir_D;

  // reference model
  int owner, last, streak;
  bit errp, skip, p_estb, p_resp, e_stb;
  bit pcyc[N];

  // statistics
  int cyc_n, first_stb, err_at;
  int ack_cnt[N], err_cnt[N];
  int seq[$];
  int e34[$] = '{0, 2};
  int e35[$] = '{0, 1, 2, 3, 0};
  int e36[$] = '{1, 3};

  int n_chk, n_pass;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic int qcode(int q[$]);
    int c = 0;
    foreach (q[i]) c = c * 8 + q[i] + 1;
    return c;
  endfunction

  task automatic give_job(int k, int nb, logic [31:0] a, bit w, bit b);
    pv[k] = 1; p_beats[k] = nb; p_adr[k] = a; p_we[k] = w; p_bst[k] = b;
  endtask

  task automatic reset_stats();
    seq.delete();
    first_stb = -1; err_at = -1;
    for (int k = 0; k < N; k++) begin ack_cnt[k] = 0; err_cnt[k] = 0; end
  endtask

  // Ownership and timeout bookkeeping at a clock edge.
  task automatic model_edge();
    bit ep;
    int old;
    old = owner;
    ep = 0;
    if (!skip) begin
      if (owner >= 0 && p_estb && !p_resp) streak++;
      else streak = 0;
      if (streak == TO) begin ep = 1; streak = 0; end
    end else streak = 0;
    if (owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (last + 1 + i) % N;
        if (pcyc[j]) begin owner = j; last = j; seq.push_back(j); break; end
      end
    end else if (!pcyc[owner]) owner = -1;
    errp = ep && (owner >= 0) && (owner == old);
    skip = 0;
  endtask

  task automatic drive();
    bit r;
    for (int k = 0; k < N; k++) begin
      m_cyc[k] = act[k];
      m_stb[k] = act[k];
      if (act[k]) begin
        m_adr[k*AW +: AW] = adr[k];
        m_dat[k*DW +: DW] = dat[k];
        m_sel[k*SW +: SW] = sel[k];
        m_we[k]           = we[k];
        m_cti[k*3 +: 3]   = bst[k] ? ((beats[k] == 1) ? 3'b111 : 3'b010) : 3'b000;
        m_bte[k*2 +: 2]   = bte[k];
      end else begin
        m_adr[k*AW +: AW] = $urandom;
        m_dat[k*DW +: DW] = $urandom;
        m_sel[k*SW +: SW] = 4'($urandom);
        m_we[k]           = 1'($urandom);
        m_cti[k*3 +: 3]   = 3'($urandom);
        m_bte[k*2 +: 2]   = 2'($urandom);
      end
    end
    r = (sl_cnt > 0) && (sl_cnt == sl_D);
    s_ack   = r && (sl_kind == 0);
    s_err   = r && (sl_kind == 1);
    s_rty   = r && (sl_kind == 2);
    s_dat_i = $urandom;
  endtask

  task automatic check();
    bit g;
    logic [N-1:0] eg, ea, ee, er;
    g = owner >= 0;
    eg = '0; ea = '0; ee = '0; er = '0;
    e_stb = 0;
    if (g) begin
      eg[owner] = 1'b1;
      e_stb = m_stb[owner] && !errp;
      ea[owner] = s_ack && m_stb[owner];
      ee[owner] = (s_err && m_stb[owner]) || (errp && !s_ack);
      er[owner] = s_rty && m_stb[owner];
    end
    chk("grant", grant, eg);
    chk("s_cyc", s_cyc, g ? m_cyc[owner] : 1'b0);
    chk("s_stb", s_stb, e_stb);
    chk("s_we",  s_we,  g ? m_we[owner] : 1'b0);
    chk("s_adr", s_adr, g ? m_adr[owner*AW +: AW] : '0);
    chk("s_dat", s_dat_o, g ? m_dat[owner*DW +: DW] : '0);
    chk("s_sel", s_sel, g ? m_sel[owner*SW +: SW] : '0);
    chk("s_cti", s_cti, g ? m_cti[owner*3 +: 3] : '0);
    chk("s_bte", s_bte, g ? m_bte[owner*2 +: 2] : '0);
    chk("m_dat", m_dat_o, s_dat_i);
    chk("m_ack", m_ack, ea);
    chk("m_err", m_err, ee);
    chk("m_rty", m_rty, er);
  endtask

  task automatic end_proc();
    int r;
    for (int k = 0; k < N; k++) pcyc[k] = m_cyc[k];
    p_estb = e_stb;
    p_resp = s_ack | s_err | s_rty;
    for (int k = 0; k < N; k++) begin
      if (m_ack[k]) ack_cnt[k]++;
      if (m_err[k]) err_cnt[k]++;
    end
    if (s_stb && first_stb < 0) first_stb = cyc_n;
    if ((|m_err) && err_at < 0) err_at = cyc_n;
    for (int k = 0; k < N; k++) begin
      if (act[k]) begin
        if (m_err[k] || m_rty[k]) act[k] = 0;
        else if (m_ack[k]) begin
          beats[k]--; adr[k] += 4; dat[k] = $urandom; sel[k] = 4'($urandom);
          if (beats[k] == 0) act[k] = 0;
        end
      end else begin
        if (!pv[k] && rand_mode && $urandom_range(3) == 0) begin
          r = $urandom_range(1, 4);
          give_job(k, r, $urandom & 32'hFFFF_FFFC, 1'($urandom), (r > 1) && 1'($urandom));
        end
        if (pv[k]) begin
          act[k] = 1; beats[k] = p_beats[k]; adr[k] = p_adr[k]; we[k] = p_we[k];
          bst[k] = p_bst[k]; dat[k] = $urandom; sel[k] = 4'($urandom);
          bte[k] = rand_mode ? 2'($urandom) : 2'b00;
          pv[k] = 0;
        end
      end
    end
    if (s_stb && !p_resp) sl_cnt++;
    else sl_cnt = 0;
    if (sl_cnt == 0) begin
      if (dir_D > 0) begin sl_D = dir_D; sl_kind = 0; end
      else begin
        sl_D = ($urandom_range(19) == 0) ? 20 : $urandom_range(1, 3);
        r = $urandom_range(19);
        sl_kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      end
    end
    cyc_n++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    drive();
    #1;
    check();
    end_proc();
  endtask

  task automatic run_quiet(int maxc);
    bit done;
    done = 0;
    for (int c = 0; c < maxc && !done; c++) begin
      step();
      done = (owner < 0);
      for (int k = 0; k < N; k++) if (act[k] || pv[k]) done = 0;
    end
    chk("quiet", done, 1'b1);
  endtask

  // Reset asserted between edges; outputs must drop without waiting for a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, '0);
    chk("rst_scyc", s_cyc, 1'b0);
    chk("rst_sstb", s_stb, 1'b0);
    chk("rst_ack", m_ack, '0);
    chk("rst_err", m_err, '0);
    owner = -1; last = N - 1; streak = 0; errp = 0; skip = 1;
    sl_cnt = 0; sl_D = (dir_D > 0) ? dir_D : 1; sl_kind = 0;
    @(posedge clk); #4 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    n_chk = 0; n_pass = 0; cyc_n = 0; rand_mode = 0; dir_D = 1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0; s_dat_i = '0; s_ack = 0; s_err = 0; s_rty = 0;
    for (int k = 0; k < N; k++) begin act[k] = 0; pv[k] = 0; pcyc[k] = 0; end
    owner = -1; last = N - 1; streak = 0; errp = 0; skip = 1;
    sl_cnt = 0; sl_D = 1; sl_kind = 0;
    reset_stats();

    #12;
    chk("reset_grant", grant, '0);
    chk("reset_scyc", s_cyc, 1'b0);
    chk("reset_sstb", s_stb, 1'b0);
    chk("reset_swe", s_we, 1'b0);
    chk("reset_sadr", s_adr, '0);
    chk("reset_acks", {m_ack, m_err, m_rty}, '0);
    rst_n = 1'b1;

    // masters 0 and 2 request together from reset
    give_job(0, 1, 32'h100, 1, 0);
    give_job(2, 1, 32'h200, 0, 0);
    step(); step(); step();
    chk("t34_first_grant", grant, 4'b0001);
    chk("t34_adr", s_adr, 32'h100);
    chk("t34_we", s_we, 1'b1);
    run_quiet(50);
    chk("t34_seq", qcode(seq), qcode(e34));
    chk("t34_ack0", ack_cnt[0], 1);

    // all four masters, single beats, master 0 returns
    do_reset(); reset_stats();
    for (int k = 0; k < N; k++) give_job(k, 1, 32'h1000 * (k + 1), 1'($urandom), 0);
    step(); step();
    give_job(0, 1, 32'h1800, 0, 0);
    run_quiet(100);
    chk("t35_seq", qcode(seq), qcode(e35));

    // 8-beat incrementing burst on master 1 with master 3 waiting
    do_reset(); reset_stats();
    give_job(1, 8, 32'h40, 1, 1);
    give_job(3, 1, 32'h400, 0, 0);
    run_quiet(100);
    chk("t36_seq", qcode(seq), qcode(e36));
    chk("t36_ack1", ack_cnt[1], 8);
    chk("t36_ack3", ack_cnt[3], 1);

    // silent slave: error after TIMEOUT cycles of strobe
    dir_D = 1000; do_reset(); reset_stats();
    give_job(0, 1, 32'h300, 0, 0);
    run_quiet(100);
    chk("t37_err_delay", err_at - first_stb, TO);
    chk("t37_err_width", err_cnt[0], 1);
    t = 0;
    for (int k = 0; k < N; k++) t += ack_cnt[k];
    chk("t37_no_ack", t, 0);

    // ack on the last cycle before the timeout wins
    dir_D = TO - 1; reset_stats();
    give_job(2, 1, 32'h500, 1, 0);
    run_quiet(100);
    chk("t38_ack", ack_cnt[2], 1);
    t = 0;
    for (int k = 0; k < N; k++) t += err_cnt[k];
    chk("t38_no_err", t, 0);

    // reset mid-burst, then clean re-arbitration
    dir_D = 1; reset_stats();
    give_job(1, 8, 32'h80, 1, 1);
    repeat (6) step();
    chk("t38_granted", grant, 4'b0010);
    do_reset();
    step();
    chk("t38_regrant", grant, 4'b0010);
    run_quiet(100);

    // randomized traffic
    dir_D = 0; do_reset(); reset_stats();
    rand_mode = 1;
    repeat (2000) step();
    rand_mode = 0;
    run_quiet(1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_burst_arbiter.md
WB_BURST_ARBITER -- requirements
Module: wb_burst_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, number of requesting Wishbone masters (2..8).
REQ-002 Parameter aw, default 32, address width.
REQ-003 Parameter dw, default 32, data width (multiple of 8).
REQ-004 Parameter TIMEOUT, default 256, cycles without slave response before the arbiter terminates the access (>=2).
REQ-005 Reset is wb_rst_i, asynchronous, active-low; clock is wb_clk_i.
REQ-006 wb_clk_i  in  1  clock.
REQ-007 wb_rst_i  in  1  reset.
REQ-008 m_adr_i  in  NUM_MASTERS*aw  master addresses, master k at slice [k*aw +: aw]; same packing for all m_* buses.
REQ-009 m_dat_i  in  NUM_MASTERS*dw  master write data.
REQ-010 m_sel_i  in  NUM_MASTERS*dw/8  master byte selects.
REQ-011 m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS each  per-master controls.
REQ-012 m_cti_i  in  NUM_MASTERS*3; m_bte_i  in  NUM_MASTERS*2  burst tags.
REQ-013 m_dat_o  out  dw  slave read data broadcast to all masters.
REQ-014 m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS each  per-master terminations.
REQ-015 s_adr_o aw, s_dat_o dw, s_sel_o dw/8, s_we_o 1, s_cyc_o 1, s_stb_o 1, s_cti_o 3, s_bte_o 2  out  shared slave port.
REQ-016 s_dat_i dw, s_ack_i 1, s_err_i 1, s_rty_i 1  in  slave responses.
REQ-017 grant_o  out  NUM_MASTERS  one-hot registered grant, all-zero when idle.

Function
REQ-018 FSM states IDLE and BUSY; state, grant, last-grant pointer and timeout counter are registers.
REQ-019 IDLE: any m_cyc_i high -> register one-hot grant, go BUSY at next edge; slave sees the access one cycle after request (1-cycle arbitration latency).
REQ-020 Selection round-robin: search starts at index (last_grant+1) mod NUM_MASTERS, wraps, picks first with m_cyc_i high; last_grant updated on each grant.
REQ-021 BUSY: all s_* outputs combinationally muxed from granted master; s_cyc_o = granted m_cyc_i.
REQ-022 Non-granted masters: m_ack_o/m_err_o/m_rty_o bits held 0.
REQ-023 Granted master's ack/err/rty bits driven combinationally from s_ack_i/s_err_i/s_rty_i, gated by its m_stb_i.
REQ-024 Grant held for the whole cycle, including every beat of CTI 001/010 bursts and the 111 end beat; no preemption while granted m_cyc_i stays high.
REQ-025 Granted m_cyc_i low in BUSY -> grant cleared and IDLE at that edge; s_cyc_o/s_stb_o low same cycle; new arbitration next cycle (one idle cycle between owners).
REQ-026 IDLE: s_cyc_o, s_stb_o, s_we_o low, other s_* outputs zero.
REQ-027 Timeout counter clears in IDLE, when s_stb_o low, or on any s_ack_i/s_err_i/s_rty_i; increments each BUSY cycle with s_stb_o high and no response.
REQ-028 Counter reaching TIMEOUT-1 -> granted m_err_o high one cycle (s_stb_o forced low that cycle), counter clears; grant kept until master drops cyc.
REQ-029 Slave ack and timeout in the same cycle: ack wins, no error issued.
REQ-030 Request arriving in the same cycle another master releases: considered at next IDLE arbitration, order per REQ-020.
REQ-031 Counter width $clog2(TIMEOUT)+1 bits; no wrap before TIMEOUT-1.

Reset
REQ-032 wb_rst_i low: state IDLE, grant_o 0, last_grant NUM_MASTERS-1 (master 0 first priority), counter 0, all s_* control outputs low, all m_ack_o/m_err_o/m_rty_o 0.
REQ-033 Reset mid-cycle aborts ownership immediately; after release, arbitration restarts per REQ-019 with no residual grant.

Verification
REQ-034 Masters 0 and 2 assert cyc same cycle from reset -> grant_o=0001 next edge, master 0 classic write to 0x100 with ack; on release grant_o=0100.
REQ-035 All 4 masters hold cyc continuously, each single-beat -> grant sequence 0,1,2,3,0 with one IDLE cycle between each.
REQ-036 Master 1 8-beat incrementing burst (CTI 010, BTE 00, last 111) from 0x40 while master 3 requests -> grant_o stays 0010 for all 8 acks, master 3 granted only after master 1 drops cyc.
REQ-037 Slave never acks, TIMEOUT=16 -> granted m_err_o pulses exactly 16 cycles after stb first high, one cycle wide; no ack to any master.
REQ-038 Slave acks on cycle TIMEOUT-1 -> ack delivered, no err; wb_rst_i pulsed low mid-burst -> grant_o=0, s_cyc_o=0 immediately, clean arbitration after release.
